// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the two-requester ALU sharing controller:
// ALU function codes, output-register FSM states and condition-code bit positions.
package alu_share_ctrl_pkg;

    typedef enum logic [1:0] {
        FnAdd = 2'b00,
        FnSub = 2'b01,
        FnAnd = 2'b10,
        FnXor = 2'b11
    } alu_fn_e;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } state_e;

    localparam logic [1:0] CcOf = 2'd0;
    localparam logic [1:0] CcZf = 2'd1;
    localparam logic [1:0] CcSf = 2'd2;

    // Reset value of cc: only ZF set.
    localparam logic [2:0] CcReset = 3'b010;

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Shared combinational ALU datapath: add/sub/and/xor plus OF/ZF/SF flags on the result.
module alu_share_ctrl_alu
    import alu_share_ctrl_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_fn_e      fn,
    output logic [N-1:0] r,
    output logic [2:0]   flags
);

    logic of;

    always_comb begin
        r  = '0;
        of = 1'b0;
        unique case (fn)
            FnAdd: begin
                r  = a + b;
                of = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            FnSub: begin
                r  = a + (~b) + N'(1);
                of = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            FnAnd: r = a & b;
            FnXor: r = a ^ b;
            default: r = '0;
        endcase

        flags       = '0;
        flags[CcOf] = of;
        flags[CcZf] = (r == '0);
        flags[CcSf] = r[N-1];
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one ALU between an execute and an auxiliary requester,
// with a single registered response slot and a condition-code register.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [1:0]   req0_fn,
    input  logic [1:0]   req1_fn,
    input  logic         req0_set_cc,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_data,
    output logic [2:0]   cc
);

    state_e       state_q, state_d;
    logic         last_q;
    logic         id_q;
    logic [N-1:0] data_q;
    logic [2:0]   cc_q;

    logic         grant_id;
    logic         accept;
    logic [N-1:0] op_a, op_b;
    alu_fn_e      op_fn;
    logic [N-1:0] alu_r;
    logic [2:0]   alu_flags;

    always_comb begin
        // Contention goes to the requester that was not granted last.
        grant_id  = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        accept    = rst_n && (req_valid != 2'b00) && ((state_q == StEmpty) || rsp_ready);
        req_ready = 2'b00;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end

        op_a  = grant_id ? req1_a : req0_a;
        op_b  = grant_id ? req1_b : req0_b;
        op_fn = alu_fn_e'(grant_id ? req1_fn : req0_fn);

        state_d = state_q;
        if (accept) begin
            state_d = StFull;
        end else if ((state_q == StFull) && rsp_ready) begin
            state_d = StEmpty;
        end
    end

    alu_share_ctrl_alu #(
        .N(N)
    ) u_alu (
        .a    (op_a),
        .b    (op_b),
        .fn   (op_fn),
        .r    (alu_r),
        .flags(alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            data_q  <= '0;
            cc_q    <= CcReset;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= alu_r;
                id_q   <= grant_id;
                last_q <= grant_id;
                if (!grant_id && req0_set_cc) begin
                    cc_q <= alu_flags;
                end
            end
        end
    end

    assign rsp_valid = (state_q == StFull);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign cc        = cc_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: the driver queues hand-computed responses on accept,
// a negedge monitor compares every presented response against the queue head.
`timescale 1ns/1ps
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_fn, req1_fn;
    logic        req0_set_cc;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [63:0] rsp_data;
    logic [2:0]  cc;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  fn;
        logic        set_cc;
        logic [63:0] r;
        logic [2:0]  cc;
    } vec_t;

    typedef struct {
        logic        id;
        logic [63:0] data;
        logic [2:0]  cc;
    } exp_t;

    vec_t vecs[9];
    exp_t q[$];
    exp_t pend[$];
    logic [2:0] cc_model;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(
        .N(64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_fn    (req0_fn),
        .req1_fn    (req1_fn),
        .req0_set_cc(req0_set_cc),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .cc         (cc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus, entered and left at posedge+1.
    task automatic cycle(input logic [1:0] v, input int i0, input int i1, input logic rr,
                         input logic [1:0] exp_rdy);
        req_valid   = v;
        req0_a      = vecs[i0].a;
        req0_b      = vecs[i0].b;
        req0_fn     = vecs[i0].fn;
        req0_set_cc = vecs[i0].set_cc;
        req1_a      = vecs[i1].a;
        req1_b      = vecs[i1].b;
        req1_fn     = vecs[i1].fn;
        rsp_ready   = rr;
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (req_valid[0] && req_ready[0]) begin
            if (vecs[i0].set_cc) cc_model = vecs[i0].cc;
            pend.push_back('{id: 1'b0, data: vecs[i0].r, cc: cc_model});
        end
        if (req_valid[1] && req_ready[1]) begin
            pend.push_back('{id: 1'b1, data: vecs[i1].r, cc: cc_model});
        end
        @(posedge clk);
        #1;
        while (pend.size() > 0) q.push_back(pend.pop_front());
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("rsp_valid", 64'(rsp_valid), 64'(q.size() != 0));
            if (rsp_valid && q.size() > 0) begin
                chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
                chk("rsp_data", rsp_data, q[0].data);
                chk("cc", 64'(cc), 64'(q[0].cc));
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b1, 64'h8000_0000_0000_0000, 3'b101};
        vecs[1] = '{64'd5, 64'd5, 2'b01, 1'b0, 64'd0, 3'b000};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b1, 64'd0, 3'b010};
        vecs[3] = '{64'd3, 64'd4, 2'b00, 1'b1, 64'd7, 3'b000};
        vecs[4] = '{64'hF0F0, 64'h0FF0, 2'b10, 1'b0, 64'h00F0, 3'b000};
        vecs[5] = '{64'd0, 64'd1, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100};
        vecs[6] = '{64'h8000_0000_0000_0000, 64'd1, 2'b01, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b1, 64'd0, 3'b010};
        vecs[8] = '{64'hA5, 64'h5A, 2'b11, 1'b0, 64'hFF, 3'b000};
        cc_model = 3'b010;

        // Reset state, with both requesters asserting valid.
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_fn = '0; req1_fn = '0; req0_set_cc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp_data", rsp_data, 64'd0);
        chk("reset rsp_id", 64'(rsp_id), 64'd0);
        chk("reset cc", 64'(cc), 64'(3'b010));
        rst_n = 1'b1;
        req_valid = 2'b00;

        // Signed overflow on add into the sign bit.
        cycle(2'b01, 0, 0, 1'b1, 2'b01);
        cycle(2'b00, 0, 0, 1'b1, 2'b00);
        // Requester 1 subtract to zero leaves cc alone.
        cycle(2'b10, 0, 1, 1'b1, 2'b10);
        cycle(2'b00, 0, 0, 1'b1, 2'b00);
        // Both valid every cycle: grants alternate 0,1,0,1.
        cycle(2'b11, 3, 4, 1'b1, 2'b01);
        cycle(2'b11, 3, 4, 1'b1, 2'b10);
        cycle(2'b11, 5, 4, 1'b1, 2'b01);
        cycle(2'b11, 6, 4, 1'b1, 2'b10);
        cycle(2'b00, 0, 0, 1'b1, 2'b00);
        // Backpressure: hold FULL three cycles, req1 request dropped, then drain+refill.
        cycle(2'b01, 7, 1, 1'b1, 2'b01);
        cycle(2'b10, 7, 1, 1'b0, 2'b00);
        cycle(2'b10, 7, 1, 1'b0, 2'b00);
        cycle(2'b10, 7, 1, 1'b0, 2'b00);
        cycle(2'b01, 8, 1, 1'b1, 2'b01);
        cycle(2'b00, 0, 0, 1'b1, 2'b00);
        cycle(2'b01, 6, 0, 1'b1, 2'b01);
        cycle(2'b00, 0, 0, 1'b1, 2'b00);
        // XOR to zero with cc update, then reset while FULL.
        cycle(2'b01, 5, 0, 1'b1, 2'b01);
        cycle(2'b01, 2, 0, 1'b1, 2'b01);
        cycle(2'b00, 0, 0, 1'b0, 2'b00);
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("midreset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midreset cc", 64'(cc), 64'(3'b010));
        chk("midreset req_ready", 64'(req_ready), 64'd0);
        chk("midreset rsp_data", rsp_data, 64'd0);
        q.delete();
        cc_model = 3'b010;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // First contended request after reset goes to requester 0.
        cycle(2'b11, 3, 4, 1'b1, 2'b01);
        cycle(2'b00, 0, 0, 1'b1, 2'b00);
        cycle(2'b00, 0, 0, 1'b1, 2'b00);
        chk("queue drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 SHALL have parameter N, default 64, meaning the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have ports req_valid[1:0] (input) and req_ready[1:0] (output), 1 bit per requester; requester 0 is execute, requester 1 is auxiliary.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b, inputs, N bits each, the operands.
REQ-006 SHALL have ports req0_fn, req1_fn, inputs, 2 bits each: 00 a+b, 01 a-b, 10 a&b, 11 a^b.
REQ-007 SHALL have port req0_set_cc, input, 1: update the condition codes with this requester-0 operation.
REQ-008 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_id (output, 1, the owning requester) and rsp_data (output, N, the result).
REQ-009 SHALL have port cc, output, 3 bits: cc[0]=OF, cc[1]=ZF, cc[2]=SF.

Function
REQ-010 SHALL instantiate a single combinational ALU shared by both requesters; only the granted requester's operands and fn drive it.
REQ-011 SHALL implement the output-register FSM with 2 states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-012 SHALL accept a request (grant) in a cycle only when in EMPTY, or when in FULL with rsp_ready=1 (drain and refill in the same cycle).
REQ-013 SHALL assert req_ready[i] combinationally, only for the requester granted that cycle; at most one req_ready bit is high per cycle.
REQ-014 SHALL arbitrate round-robin: a last-grant pointer (reset 1) gives priority to the requester other than the last granted; a sole requester wins regardless of the pointer.
REQ-015 SHALL update the last-grant pointer only on an accepted transfer (req_valid[i] & req_ready[i]).
REQ-016 SHALL register rsp_data and rsp_id on accept: latency exactly 1 cycle from accept edge to rsp_valid=1.
REQ-017 SHALL hold rsp_data and rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-018 SHALL, on FULL with rsp_ready=1 and no accept, go to EMPTY; on accept, go or stay FULL.
REQ-019 SHALL sustain 1 operation per cycle when rsp_ready is held high.
REQ-020 SHALL compute results modulo 2^N; subtraction is a + ~b + 1.
REQ-021 SHALL define flags on the ALU result r: ZF = (r == 0) over all N bits; SF = r[N-1].
REQ-022 SHALL define OF for fn 00 as a[N-1]==b[N-1] and r[N-1]!=a[N-1]; for fn 01 as a[N-1]!=b[N-1] and r[N-1]!=a[N-1]; for fn 1x as 0.
REQ-023 SHALL write cc on the accept edge only when requester 0 is accepted with req0_set_cc=1; a requester-1 accept never alters cc.
REQ-024 SHALL ignore operand and fn inputs of non-granted or non-valid requesters; a request dropped before accept has no effect.

Reset
REQ-025 SHALL, while rst_n=0, force FSM=EMPTY, rsp_valid=0, rsp_data=0, rsp_id=0, cc=3'b010 (ZF set), last-grant pointer=1.
REQ-026 SHALL discard any in-flight response on reset mid-operation; req_ready SHALL be 0 while rst_n=0.
REQ-027 SHALL grant the first request after reset deassertion to requester 0 when both are valid.

Structure
REQ-028 SHALL take the fn encodings (ADD, SUB, AND, XOR), the FSM state encoding and the cc bit indices from a shared package.
REQ-029 SHALL contain exactly one sub-module instance: the shared ALU datapath (module ALU, parameter N); arbitration, FSM and cc register stay in alu_share_ctrl.

Verification
REQ-030 SHALL cover: after reset, req0 fn=00, a=0x7FFFFFFFFFFFFFFF, b=1, set_cc=1 -> next cycle rsp_data=0x8000000000000000, rsp_id=0, cc=3'b101.
REQ-031 SHALL cover: both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1, one response per cycle, rsp_id alternating.
REQ-032 SHALL cover: req1 fn=01, a=5, b=5 -> rsp_data=0, rsp_id=1, cc unchanged from its prior value.
REQ-033 SHALL cover: rsp_ready=0 for 3 cycles while FULL -> req_ready=00, rsp_data and rsp_id stable; rsp_ready=1 with pending req0 -> drain and accept in the same cycle.
REQ-034 SHALL cover: req0 fn=11, a=b=0xFFFFFFFFFFFFFFFF, set_cc=1 -> rsp_data=0, cc=3'b010; then rst_n pulsed low while FULL -> rsp_valid=0 immediately, cc=3'b010.
